// File: rtl/lfsr_reduce_engine_if.sv
// Handshake/data bundle for lfsr_reduce_engine.
// master: drives en/start/mode/seed/seed_ld, observes rnd/cnt/busy/done/y.
// slave:  the engine side of the same signals.
interface lfsr_reduce_engine_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 7
);
    logic             en;
    logic             start;
    logic [1:0]       mode;
    logic [W-1:0]     seed;
    logic             seed_ld;
    logic [W-1:0]     rnd;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
    logic [W-1:0]     y;

    modport master (
        output en, start, mode, seed, seed_ld,
        input  rnd, cnt, busy, done, y
    );

    modport slave (
        input  en, start, mode, seed, seed_ld,
        output rnd, cnt, busy, done, y
    );
endinterface

// File: rtl/lfsr_reduce_engine.sv
// Iterative Galois-LFSR sample generator with a per-run fold (min/max/AND/OR).
// Ports:
//   clk  - clock, all state updates on rising edge
//   rst  - synchronous active-high reset, highest priority
//   bus  - slave side of lfsr_reduce_engine_if:
//          en (global advance), start, mode, seed, seed_ld in;
//          rnd (LFSR state), cnt (samples consumed), busy, done pulse, y (result) out
module lfsr_reduce_engine #(
    parameter int unsigned   W            = 32,
    parameter int unsigned   N_ITER       = 100,
    parameter int unsigned   CNT_W        = 7,
    parameter logic [W-1:0]  TAPS         = W'(32'h80200003),
    parameter logic [W-1:0]  SEED_DEFAULT = W'(1)
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_reduce_engine_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     rnd_q, rnd_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     folded_c;

    // One Galois step; the shifted-out bit selects whether the tap mask is applied.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] r);
        return r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
    endfunction

    // Neutral starting accumulator so the first sample passes through unchanged.
    function automatic logic [W-1:0] identity(input logic [1:0] m);
        return (m == 2'b00 || m == 2'b10) ? '1 : '0;
    endfunction

    // Fold of the current sample into the accumulator; ties keep acc.
    always_comb begin
        folded_c = acc_q;
        case (mode_q)
            2'b00:   if (rnd_q < acc_q) folded_c = rnd_q;
            2'b01:   if (rnd_q > acc_q) folded_c = rnd_q;
            2'b10:   folded_c = acc_q & rnd_q;
            default: folded_c = acc_q | rnd_q;
        endcase
    end

    // Next-state and register-update logic; en=0 holds everything and drops done.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (bus.seed_ld) begin
                        rnd_d = (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
                    end
                    if (bus.start) begin
                        mode_d  = bus.mode;
                        cnt_d   = '0;
                        acc_d   = identity(bus.mode);
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
                RUN: begin
                    acc_d = folded_c;
                    rnd_d = lfsr_step(rnd_q);
                    if (cnt_q == LAST_CNT) begin
                        // cnt saturates here rather than wrapping
                        y_d     = folded_c;
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= SEED_DEFAULT;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rnd  = rnd_q;
    assign bus.cnt  = cnt_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
endmodule

// File: tb/tb_lfsr_reduce_engine.sv
// Self-checking bench for lfsr_reduce_engine (W=8, N_ITER=4, TAPS=8'hB8).
module tb_lfsr_reduce_engine;
    localparam int unsigned W     = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned CW    = 3;
    localparam logic [7:0]  TAPS  = 8'hB8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [7:0] m_rnd;
    logic [7:0] m_y;

    lfsr_reduce_engine_if #(.W(W), .CNT_W(CW)) bus ();

    lfsr_reduce_engine #(
        .W(W), .N_ITER(N), .CNT_W(CW), .TAPS(TAPS), .SEED_DEFAULT(8'h01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lf(input logic [7:0] r);
        return r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
    endfunction

    function automatic logic [7:0] fold_ref(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        case (m)
            2'd0:    return (b < a) ? b : a;
            2'd1:    return (b > a) ? b : a;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // One complete run with optional reseed, random en stalls and ignored start/seed_ld noise.
    task automatic run(input logic [1:0] m, input bit ld, input logic [7:0] sd, input int stall_pct);
        logic [7:0] s[$];
        logic [7:0] r;
        logic [7:0] exp_y;
        int k;
        int guard;
        bit e;
        r = m_rnd;
        if (ld) r = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < int'(N); i++) begin
            s.push_back(r);
            r = lf(r);
        end
        exp_y = s[0];
        for (int i = 1; i < int'(N); i++) exp_y = fold_ref(m, exp_y, s[i]);

        bus.en = 1'b1; bus.start = 1'b1; bus.mode = m; bus.seed_ld = ld; bus.seed = sd;
        step();
        bus.start = 1'b0; bus.seed_ld = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("cnt_after_start", 32'(bus.cnt), 0);
        chk("y_held_at_start", 32'(bus.y), 32'(m_y));
        chk("rnd_first_sample", 32'(bus.rnd), 32'(s[0]));

        k = 0;
        guard = 0;
        while (k < int'(N) && guard < 200) begin
            e = ($urandom_range(99) >= 32'(stall_pct));
            bus.en      = e;
            bus.start   = 1'($urandom_range(1));
            bus.seed_ld = 1'($urandom_range(1));
            bus.seed    = 8'($urandom);
            bus.mode    = 2'($urandom);
            step();
            guard++;
            if (e) k++;
            if (k < int'(N)) begin
                chk("busy_in_run", 32'(bus.busy), 1);
                chk("done_in_run", 32'(bus.done), 0);
                chk("cnt_in_run", 32'(bus.cnt), 32'(k));
                chk("rnd_in_run", 32'(bus.rnd), 32'(s[k]));
            end
        end
        if (guard >= 200) chk("run_timeout", 32'(k), 32'(N));

        bus.start = 1'b0; bus.seed_ld = 1'b0;
        chk("done_pulse", 32'(bus.done), 1);
        chk("busy_at_done", 32'(bus.busy), 0);
        chk("y_result", 32'(bus.y), 32'(exp_y));
        chk("rnd_after_run", 32'(bus.rnd), 32'(r));
        chk("cnt_saturated", 32'(bus.cnt), 32'(N - 1));

        if (stall_pct > 0 && $urandom_range(1) == 1) begin
            bus.en = 1'b0;
            step();
            chk("done_dropped_on_stall", 32'(bus.done), 0);
            chk("y_held_on_stall", 32'(bus.y), 32'(exp_y));
        end
        bus.en = 1'b1;
        step();
        chk("done_one_cycle", 32'(bus.done), 0);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("y_held_idle", 32'(bus.y), 32'(exp_y));
        m_rnd = r;
        m_y   = exp_y;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_rnd = 8'h01;
        m_y   = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1; bus.start = 1'b0; bus.mode = 2'd0; bus.seed = 8'h00; bus.seed_ld = 1'b0;
        do_reset();
        chk("rst_rnd", 32'(bus.rnd), 32'h01);
        chk("rst_cnt", 32'(bus.cnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_y", 32'(bus.y), 0);

        // Directed runs with known answers
        run(2'd1, 1'b0, 8'h00, 0);
        chk("s1_y", 32'(bus.y), 32'hB8);
        chk("s1_rnd", 32'(bus.rnd), 32'h17);
        run(2'd0, 1'b0, 8'h00, 0);
        chk("s2_min_y", 32'(bus.y), 32'h17);
        run(2'd1, 1'b1, 8'h01, 0);
        chk("s2_reseed_y", 32'(bus.y), 32'hB8);

        do_reset();
        run(2'd2, 1'b0, 8'h00, 0);
        chk("s3_and_y", 32'(bus.y), 32'h00);
        run(2'd3, 1'b1, 8'h01, 0);
        chk("s3_or_y", 32'(bus.y), 32'hFF);

        // Zero seed substitution and en gating of seed_ld
        bus.seed_ld = 1'b1; bus.seed = 8'h00; bus.en = 1'b1;
        step();
        chk("seed_zero", 32'(bus.rnd), 32'h01);
        bus.seed = 8'h5A;
        step();
        chk("seed_5a", 32'(bus.rnd), 32'h5A);
        bus.en = 1'b0; bus.seed = 8'h33;
        step();
        chk("seed_ld_stalled", 32'(bus.rnd), 32'h5A);
        bus.en = 1'b1; bus.seed_ld = 1'b0;
        m_rnd = 8'h5A;
        run(2'd1, 1'b0, 8'h00, 0);

        // Reset mid-run abandons the run
        bus.start = 1'b1; bus.mode = 2'd1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_y", 32'(bus.y), 0);
        chk("midrst_cnt", 32'(bus.cnt), 0);
        chk("midrst_rnd", 32'(bus.rnd), 32'h01);
        m_rnd = 8'h01;
        m_y   = 8'h00;
        run(2'd1, 1'b0, 8'h00, 0);
        chk("post_rst_y", 32'(bus.y), 32'hB8);

        // Randomized runs with stalls, reseeds and noise
        for (int i = 0; i < 30; i++) begin
            run(2'($urandom_range(3)), 1'($urandom_range(1)), 8'($urandom), 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
